// File: rtl/rr_arbiter8.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter8
// Purpose  : 8-way round-robin arbiter with a bounded grant hold time.
//            A rotating priority pointer picks the first requester at or
//            after the pointer; the grant is held until the owner signals
//            done, drops its request, or has held it for MAX_HOLD cycles.
//            Every release is followed by one idle cycle with grant=0.
// Ports    : clk         - clock, rising edge active
//            rst         - synchronous active-high reset
//            req[7:0]    - request lines, bit i = requester i
//            done        - current owner finished (ignored while idle)
//            grant[7:0]  - registered one-hot (or zero) grant
//            grant_valid - registered, high exactly when grant != 0
//            timeout     - registered one-cycle pulse after a hold-limit
//                          revocation
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter8 #(
   parameter int MAX_HOLD = 16   // legal range 1..255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   input  logic       done,
   output logic [7:0] grant,
   output logic       grant_valid,
   output logic       timeout
);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_t;

   // Last hold-counter value of a grant; the counter starts at 0 in the
   // first grant cycle, so reaching this value means MAX_HOLD cycles held.
   localparam logic [7:0] c_hold_last = 8'(MAX_HOLD - 1);

   state_t     r_state;
   logic [2:0] r_ptr;
   logic [2:0] r_idx;
   logic [7:0] r_hold;
   logic [7:0] r_grant;
   logic       r_grant_valid;
   logic       r_timeout;

   logic [2:0] w_win_idx;
   logic       w_any_req;
   logic       w_owner_req;
   logic       w_limit;
   logic       w_release;
   logic       w_timeout;

   // Rotating priority search. The loop runs from the lowest priority
   // (ptr+7) down to the highest (ptr), so the last hit wins. The 3-bit
   // sum wraps modulo 8 on its own.
   always_comb begin
      w_win_idx = r_ptr;
      for (int k = 7; k >= 0; k--) begin
         if (req[r_ptr + 3'(k)]) begin
            w_win_idx = r_ptr + 3'(k);
         end
      end
   end

   assign w_any_req   = |req;
   assign w_owner_req = req[r_idx];
   assign w_limit     = (r_hold == c_hold_last);
   assign w_release   = done | ~w_owner_req | w_limit;
   // A timeout is reported only when the hold limit is the sole reason.
   assign w_timeout   = w_limit & ~done & w_owner_req;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_ptr         <= 3'd0;
         r_idx         <= 3'd0;
         r_hold        <= 8'd0;
         r_grant       <= 8'h00;
         r_grant_valid <= 1'b0;
         r_timeout     <= 1'b0;
      end else begin
         r_timeout <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_any_req) begin
                  r_state       <= S_GRANT;
                  r_idx         <= w_win_idx;
                  r_grant       <= 8'h01 << w_win_idx;
                  r_grant_valid <= 1'b1;
                  r_hold        <= 8'd0;
               end else begin
                  r_grant       <= 8'h00;
                  r_grant_valid <= 1'b0;
               end
            end
            S_GRANT: begin
               if (w_release) begin
                  // Returning to IDLE forces the one-cycle zero gap.
                  r_state       <= S_IDLE;
                  r_grant       <= 8'h00;
                  r_grant_valid <= 1'b0;
                  r_ptr         <= r_idx + 3'd1;
                  r_timeout     <= w_timeout;
               end else begin
                  r_hold <= r_hold + 8'd1;
               end
            end
            default: begin
               r_state       <= S_IDLE;
               r_grant       <= 8'h00;
               r_grant_valid <= 1'b0;
            end
         endcase
      end
   end

   assign grant       = r_grant;
   assign grant_valid = r_grant_valid;
   assign timeout     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter8.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arbiter8
// Purpose  : Self-checking bench for rr_arbiter8 (MAX_HOLD = 4). A cycle
//            model tracks owner / pointer / cycles-held and is compared with
//            the DUT after every rising edge; directed literal checks pin the
//            model at the interesting points.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter8;

   localparam int MH = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req;
   logic       done;
   logic [7:0] grant;
   logic       grant_valid;
   logic       timeout;

   int n_checks = 0;
   int n_pass   = 0;

   rr_arbiter8 #(.MAX_HOLD(MH)) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .done        (done),
      .grant       (grant),
      .grant_valid (grant_valid),
      .timeout     (timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   // owner = index holding the grant (-1 when none), held = cycles the
   // current owner has had the grant so far (1 in its first cycle).
   int         m_owner = -1;
   int         m_ptr   = 0;
   int         m_held  = 0;
   logic       m_to    = 1'b0;
   bit         m_live  = 1'b0;
   logic [7:0] m_grant;

   always @(posedge clk) begin
      if (rst) begin
         m_owner = -1;
         m_ptr   = 0;
         m_held  = 0;
         m_to    = 1'b0;
         m_live  = 1'b1;
      end else if (m_live) begin
         m_to = 1'b0;
         if (m_owner < 0) begin
            for (int k = 0; k < 8; k++) begin
               if (m_owner < 0 && req[(m_ptr + k) % 8]) begin
                  m_owner = (m_ptr + k) % 8;
                  m_held  = 1;
               end
            end
         end else if (done || !req[m_owner] || m_held == MH) begin
            m_to    = (m_held == MH) && !done && req[m_owner];
            m_ptr   = (m_owner + 1) % 8;
            m_owner = -1;
         end else begin
            m_held = m_held + 1;
         end
      end
      m_grant = (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
      #1;
      if (m_live) begin
         chk("cyc_grant", {24'd0, grant}, {24'd0, m_grant});
         chk("cyc_valid", {31'd0, grant_valid}, {31'd0, (m_grant != 8'h00)});
         chk("cyc_timeout", {31'd0, timeout}, {31'd0, m_to});
         chk("cyc_onehot0", {31'd0, $onehot0(grant)}, 32'd1);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic lit(input string name, input logic [7:0] g, input logic t);
      chk({name, "_grant"}, {24'd0, grant}, {24'd0, g});
      chk({name, "_valid"}, {31'd0, grant_valid}, {31'd0, (g != 8'h00)});
      chk({name, "_timeout"}, {31'd0, timeout}, {31'd0, t});
   endtask

   initial begin
      rst  = 1'b1;
      req  = 8'h00;
      done = 1'b0;
      tick(2);
      lit("reset", 8'h00, 1'b0);
      rst = 1'b0;

      // single requester, released by done
      req = 8'h01;
      tick(1);
      lit("r024_grant", 8'h01, 1'b0);
      done = 1'b1;
      tick(1);
      lit("r024_release", 8'h00, 1'b0);
      done = 1'b0;
      req  = 8'h00;
      tick(1);

      // full rotation with all requesters active
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      req = 8'hFF;
      tick(1);
      for (int i = 0; i < 9; i++) begin
         lit($sformatf("r025_g%0d", i), 8'h01 << (i % 8), 1'b0);
         done = 1'b1;
         tick(1);
         lit($sformatf("r025_gap%0d", i), 8'h00, 1'b0);
         done = 1'b0;
         if (i == 8) req = 8'h00;
         tick(1);
      end

      // pointer wrap after requester 7
      req = 8'h80;
      tick(1);
      lit("r026_g80", 8'h80, 1'b0);
      done = 1'b1;
      req  = 8'h81;
      tick(1);
      lit("r026_gap", 8'h00, 1'b0);
      done = 1'b0;
      tick(1);
      lit("r026_wrap", 8'h01, 1'b0);
      req = 8'h00;
      tick(1);
      lit("r026_drop", 8'h00, 1'b0);

      // hold-limit revocation and re-grant
      req = 8'h10;
      for (int i = 0; i < MH; i++) begin
         tick(1);
         lit($sformatf("r027_hold%0d", i), 8'h10, 1'b0);
      end
      tick(1);
      lit("r027_timeout", 8'h00, 1'b1);
      tick(1);
      lit("r027_regrant", 8'h10, 1'b0);
      req = 8'h00;
      tick(1);
      lit("r027_drop", 8'h00, 1'b0);

      // done coinciding with the hold limit: normal release
      req = 8'h10;
      tick(MH);
      lit("r019_last", 8'h10, 1'b0);
      done = 1'b1;
      tick(1);
      lit("r019_done_lim", 8'h00, 1'b0);
      done = 1'b0;
      tick(1);
      lit("r019_regrant", 8'h10, 1'b0);
      // request drop coinciding with the hold limit: normal release
      tick(MH - 1);
      req = 8'h00;
      tick(1);
      lit("r019_drop_lim", 8'h00, 1'b0);
      tick(1);

      // done while idle is ignored; drop of owner request; pointer advance
      done = 1'b1;
      req  = 8'h04;
      tick(1);
      lit("r021_g04", 8'h04, 1'b0);
      done = 1'b0;
      req  = 8'h0A;
      tick(1);
      lit("r028_drop", 8'h00, 1'b0);
      tick(1);
      lit("r028_g08", 8'h08, 1'b0);
      done = 1'b1;
      tick(1);
      lit("r028_rel", 8'h00, 1'b0);
      done = 1'b0;
      req  = 8'h00;
      tick(1);

      // reset mid-grant
      req = 8'h20;
      tick(1);
      lit("r029_g20", 8'h20, 1'b0);
      rst = 1'b1;
      tick(1);
      lit("r029_rst", 8'h00, 1'b0);
      rst = 1'b0;
      req = 8'hFF;
      tick(1);
      lit("r029_g01", 8'h01, 1'b0);

      // timed-out requester does not win again ahead of others
      tick(MH);
      lit("r020_timeout", 8'h00, 1'b1);
      tick(1);
      lit("r020_next", 8'h02, 1'b0);
      req = 8'h00;
      tick(3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
